// File: rtl/sap_core_param.sv
// sap_core_param: parametrised SAP-class accumulator CPU with program-load port
`timescale 1ns/1ps
module sap_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              flag_c,
    output logic              flag_z,
    output logic [ADDR_W-1:0] pc_dbg
);
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc, mar, n, wa;
    logic [DATA_W-1:0] ir, a, b, rd, diff, wd;
    logic [DATA_W:0]   sum;
    logic [3:0]        op;
    logic              mem_we;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign op     = ir[DATA_W-1 -: 4];
    assign n      = ir[ADDR_W-1:0];
    assign rd     = mem[mar];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = a - b;
    assign pc_dbg = pc;
    // Loader owns the memory port in IDLE; otherwise only STA at T4 writes, and never under reset.
    assign mem_we = rst_n && ((state == IDLE && prog_we) || (state == T4 && op == OP_STA));
    assign wa     = state == IDLE ? prog_addr : mar;
    assign wd     = state == IDLE ? prog_data : a;

    // Program memory: not reset, single write port shared by loader and STA
    always_ff @(posedge clk) begin
        if (mem_we) mem[wa] <= wd;
    end

    // Control FSM and datapath registers, one T-state per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: state <= run ? T0 : IDLE;
                T0: begin
                    mar   <= pc;
                    state <= T1;
                end
                T1: begin
                    pc    <= pc + 1'b1;
                    state <= T2;
                end
                T2: begin
                    ir    <= rd;
                    state <= T3;
                end
                T3: begin
                    state <= op == OP_HLT ? HALT : T4;
                    if (op == OP_HLT) halted <= 1'b1;
                    if (op <= OP_STA) mar <= n;
                    if (op == OP_JMP || (op == OP_JC && flag_c) || (op == OP_JZ && flag_z)) pc <= n;
                end
                T4: begin
                    state <= T5;
                    if (op == OP_LDA) begin
                        a      <= rd;
                        flag_z <= rd == '0;
                    end
                    if (op == OP_ADD || op == OP_SUB) b <= rd;
                    if (op == OP_LDI) begin
                        a      <= DATA_W'(n);
                        flag_z <= n == '0;
                    end
                end
                T5: begin
                    state <= run ? T0 : IDLE;
                    if (op == OP_ADD) begin
                        a      <= sum[DATA_W-1:0];
                        flag_c <= sum[DATA_W];
                        flag_z <= sum[DATA_W-1:0] == '0;
                    end
                    if (op == OP_SUB) begin
                        a      <= diff;
                        flag_c <= a >= b;
                        flag_z <= diff == '0;
                    end
                    if (op == OP_OUT) begin
                        out_data  <= a;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_sap_core_param.sv
// tb_sap_core_param: directed program tests for sap_core_param
`timescale 1ns/1ps
module tb_sap_core_param;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid, halted, flag_c, flag_z;
    logic [AW-1:0] pc_dbg;

    int            vectors = 0;
    int            errs = 0;
    logic [DW-1:0] outs[$];

    sap_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid), .halted(halted),
        .flag_c(flag_c), .flag_z(flag_z), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] oq(input int i);
        return i < outs.size() ? outs[i] : 'x;
    endfunction

    task automatic poke(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = ad;
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        prog_we = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        outs.delete();
        run = 1'b1;
        for (int k = 0; k < budget && !halted; k++) begin
            @(negedge clk);
            if (out_valid) outs.push_back(out_data);
        end
        run = 1'b0;
        chk("halt_within_budget", 32'(halted), 1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   p;
        logic wrap;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_outputs", {out_data, out_valid, halted, flag_c, flag_z, pc_dbg}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LDA 14, ADD 15, OUT, HLT with 5 + 3
        poke(0, 8'h0E); poke(1, 8'h1F); poke(2, 8'hE0); poke(3, 8'hF0);
        poke(14, 8'h05); poke(15, 8'h03);
        run_to_halt(300);
        chk("add_pulses", outs.size(), 1);
        chk("add_out", oq(0), 8'h08);
        chk("add_c", 32'(flag_c), 0);
        chk("add_z", 32'(flag_z), 0);
        chk("add_pc", 32'(pc_dbg), 4);
        repeat (12) @(negedge clk);
        chk("halt_pc_frozen", 32'(pc_dbg), 4);
        chk("halt_out_frozen", 32'(out_data), 8'h08);

        // SUB with borrow, then without
        do_reset();
        poke(1, 8'h2F); poke(14, 8'h03); poke(15, 8'h05);
        run_to_halt(300);
        chk("sub_borrow_out", oq(0), 8'hFE);
        chk("sub_borrow_c", 32'(flag_c), 0);
        chk("sub_borrow_z", 32'(flag_z), 0);
        do_reset();
        poke(14, 8'h05); poke(15, 8'h03);
        run_to_halt(300);
        chk("sub_out", oq(0), 8'h02);
        chk("sub_c", 32'(flag_c), 1);

        // Countdown loop: LDI 3, OUT, SUB 15, JZ 5, JMP 1, HLT
        do_reset();
        poke(0, 8'h43); poke(1, 8'hE0); poke(2, 8'h2F); poke(3, 8'h75);
        poke(4, 8'h51); poke(5, 8'hF0); poke(15, 8'h01);
        run_to_halt(600);
        chk("cd_pulses", outs.size(), 3);
        chk("cd_out0", oq(0), 3);
        chk("cd_out1", oq(1), 2);
        chk("cd_out2", oq(2), 1);
        chk("cd_z", 32'(flag_z), 1);
        chk("cd_c", 32'(flag_c), 1);

        // STA then reload, then read back after halt
        do_reset();
        poke(0, 8'h49); poke(1, 8'h3C); poke(2, 8'h40); poke(3, 8'h0C);
        poke(4, 8'hE0); poke(5, 8'hF0);
        run_to_halt(300);
        chk("sta_out", oq(0), 8'h09);
        do_reset();
        poke(0, 8'h0C); poke(1, 8'hE0); poke(2, 8'hF0);
        run_to_halt(300);
        chk("sta_readback", oq(0), 8'h09);

        // Sixteen NOPs: PC wrap, stop at boundary, prog_we ignored while running
        do_reset();
        for (int i = 0; i < 16; i++) poke(AW'(i), 8'h80);
        run = 1'b1;
        wrap = 1'b0;
        p = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 50) begin
                prog_we = 1'b1;
                prog_addr = 10;
                prog_data = 8'h77;
            end
            if (c == 51) prog_we = 1'b0;
            if (p == 15 && pc_dbg == 0) wrap = 1'b1;
            p = int'(pc_dbg);
        end
        chk("pc_wrap", 32'(wrap), 1);
        run = 1'b0;
        repeat (8) @(negedge clk);
        chk("stop_pc", 32'(pc_dbg), 1);
        repeat (12) @(negedge clk);
        chk("stop_pc_stable", 32'(pc_dbg), 1);
        do_reset();
        poke(0, 8'h0A); poke(1, 8'hE0); poke(2, 8'hF0);
        run_to_halt(300);
        chk("run_we_ignored", oq(0), 8'h80);

        // Drop run mid-OUT: instruction completes, then resume from current PC
        do_reset();
        poke(0, 8'h46); poke(1, 8'hE0); poke(2, 8'h41); poke(3, 8'hE0); poke(4, 8'hF0);
        outs.delete();
        run = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 8) run = 1'b0;
            if (out_valid) outs.push_back(out_data);
        end
        chk("stop_pulses", outs.size(), 1);
        chk("stop_out", oq(0), 8'h06);
        chk("stop_at_pc", 32'(pc_dbg), 2);
        chk("stop_not_halted", 32'(halted), 0);
        run_to_halt(300);
        chk("resume_out", oq(0), 8'h01);
        chk("resume_pc", 32'(pc_dbg), 5);

        // Async reset during T4 of STA 12 aborts the write
        do_reset();
        poke(0, 8'h49); poke(1, 8'hE0); poke(2, 8'h3C); poke(3, 8'hF0); poke(12, 8'h55);
        run = 1'b1;
        repeat (17) @(negedge clk);
        chk("pre_rst_out", 32'(out_data), 8'h09);
        chk("pre_rst_pc", 32'(pc_dbg), 3);
        run = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {out_data, out_valid, halted, flag_c, flag_z, pc_dbg}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        poke(0, 8'h0C); poke(1, 8'hE0); poke(2, 8'hF0);
        run_to_halt(300);
        chk("rst_abort_mem", oq(0), 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
